// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin front end sharing one pipelined fp_mult
// among NUM_REQ requesters, with tagged in-order responses.
module fp_mult_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_mask,
  output logic [31:0]             mult_a,
  output logic [31:0]             mult_b,
  input  logic [31:0]             mult_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    busy
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    nxt_ptr;
  logic [NUM_REQ-1:0] cand;
  logic [ID_W-1:0]    idx;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        win_a;
  logic [31:0]        win_b;
  logic               xfer;

  logic               iss_vld;
  logic [ID_W-1:0]    iss_id;
  logic               tag_vld [MULT_LATENCY];
  logic [ID_W-1:0]    tag_id  [MULT_LATENCY];
  logic               tail_vld;
  logic [ID_W-1:0]    tail_id;
  logic [3:0]         cnt;

  always_comb begin
    cand    = req_valid & req_mask;
    idx     = '0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_vld && cand[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
    if (!reset_n) win_vld = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    win_a     = '0;
    win_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == ID_W'(i)) begin
        win_a = req_a[32*i +: 32];
        win_b = req_b[32*i +: 32];
      end
    end
    if (win_vld) req_ready[win_id] = 1'b1;
  end

  assign xfer     = win_vld;
  assign nxt_ptr  = (int'(win_id) == NUM_REQ-1) ? '0 : win_id + 1'b1;
  assign tail_vld = tag_vld[MULT_LATENCY-1];
  assign tail_id  = tag_id[MULT_LATENCY-1];
  assign busy     = (cnt != 4'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      mult_a <= '0;
      mult_b <= '0;
    end else if (xfer) begin
      rr_ptr <= nxt_ptr;
      mult_a <= win_a;
      mult_b <= win_b;
    end
  end

  // Issue stage tags the operands on mult_a/b; the shift register then
  // tracks them through the fp_mult pipeline until mult_result is ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      iss_vld <= 1'b0;
      iss_id  <= '0;
      for (int k = 0; k < MULT_LATENCY; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= '0;
      end
    end else begin
      iss_vld    <= xfer;
      iss_id     <= win_id;
      tag_vld[0] <= iss_vld;
      tag_id[0]  <= iss_id;
      for (int k = 1; k < MULT_LATENCY; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tail_vld;
      if (tail_vld) begin
        rsp_id   <= tail_id;
        rsp_data <= mult_result;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else begin
      unique case ({xfer, tail_vld})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule
